mc_ctrl: RTL and testbench



---
 rtl/mc_pkg.sv | 71 +++++++
 rtl/mc_decode.sv | 35 +++
 rtl/mc_ctrl.sv | 165 ++++++++++++++++
 tb/tb_mc_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared encodings for the multicycle control unit
package mc_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_IF   = 3'd1,
    S_ID   = 3'd2,
    S_EXE  = 3'd3,
    S_MEM  = 3'd4,
    S_WB   = 3'd5
  } state_t;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_OR   = 3'b010;
  localparam logic [2:0] ALU_SLT  = 3'b011;
  localparam logic [2:0] ALU_ADDO = 3'b100;
  localparam logic [2:0] ALU_LUI  = 3'b101;
  localparam logic [2:0] ALU_GTZ  = 3'b110;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] F_JR   = 6'b001000;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_SLT  = 6'b101010;

  localparam logic [1:0] EXT_ZERO  = 2'b00;
  localparam logic [1:0] EXT_SIGN  = 2'b01;
  localparam logic [1:0] EXT_UPPER = 2'b10;

  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;
  localparam logic [1:0] DST_RA = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [1:0] NPC_PC4 = 2'b00;
  localparam logic [1:0] NPC_BR  = 2'b01;
  localparam logic [1:0] NPC_J   = 2'b10;
  localparam logic [1:0] NPC_RS  = 2'b11;

  typedef struct packed {
    logic addu;
    logic subu;
    logic slt;
    logic jr;
    logic ori;
    logic addi;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic bgtz;
    logic j;
    logic jal;
    logic ill;
  } instr_cls_t;

endpackage

// File: rtl/mc_decode.sv
// rtl/mc_decode.sv - combinational op/funct to one-hot instruction class
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] i_op,
  input  logic [5:0] i_funct,
  output instr_cls_t o_cls
);

  always_comb begin
    o_cls = '0;
    case (i_op)
      OP_RTYPE: begin
        case (i_funct)
          F_ADDU:  o_cls.addu = 1'b1;
          F_SUBU:  o_cls.subu = 1'b1;
          F_SLT:   o_cls.slt  = 1'b1;
          F_JR:    o_cls.jr   = 1'b1;
          default: o_cls.ill  = 1'b1;
        endcase
      end
      OP_J:    o_cls.j    = 1'b1;
      OP_JAL:  o_cls.jal  = 1'b1;
      OP_BEQ:  o_cls.beq  = 1'b1;
      OP_BGTZ: o_cls.bgtz = 1'b1;
      OP_ADDI: o_cls.addi = 1'b1;
      OP_ORI:  o_cls.ori  = 1'b1;
      OP_LUI:  o_cls.lui  = 1'b1;
      OP_LW:   o_cls.lw   = 1'b1;
      OP_SW:   o_cls.sw   = 1'b1;
      default: o_cls.ill  = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multicycle FSM sequencing IF/ID/EXE/MEM/WB with retired count
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             overflow,
  input  logic             condition,
  output logic             pc_wr,
  output logic             ir_wr,
  output logic [1:0]       npc_op,
  output logic             alu_src,
  output logic [2:0]       alu_op,
  output logic [1:0]       ext_op,
  output logic             reg_wr,
  output logic [1:0]       reg_dst,
  output logic [1:0]       wb_sel,
  output logic             mem_wr,
  output logic             illegal,
  output logic             ov_trap,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_cnt
);

  state_t           r_state;
  state_t           w_next;
  logic             r_ov_q;
  logic [CNT_W-1:0] r_instr_cnt;
  instr_cls_t       w_cls;
  logic             w_rtype;
  logic             w_retire;

  mc_decode u_decode (
    .i_op    (op),
    .i_funct (funct),
    .o_cls   (w_cls)
  );

  assign w_rtype   = w_cls.addu | w_cls.subu | w_cls.slt;
  assign w_retire  = (r_state != S_IDLE) && (r_state != S_IF) && (w_next == S_IF);
  assign state     = r_state;
  assign instr_cnt = r_instr_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_ov_q      <= 1'b0;
      r_instr_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_EXE)
        r_ov_q <= w_cls.addi & overflow;
      else if (r_state == S_WB)
        r_ov_q <= 1'b0;
      if (w_retire)
        r_instr_cnt <= r_instr_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    w_next  = r_state;
    pc_wr   = 1'b0;
    ir_wr   = 1'b0;
    npc_op  = NPC_PC4;
    alu_src = 1'b0;
    alu_op  = ALU_ADD;
    ext_op  = EXT_ZERO;
    reg_wr  = 1'b0;
    reg_dst = DST_RT;
    wb_sel  = WB_ALU;
    mem_wr  = 1'b0;
    illegal = 1'b0;
    ov_trap = 1'b0;
    case (r_state)
      S_IDLE: w_next = S_IF;
      S_IF: begin
        ir_wr  = 1'b1;
        pc_wr  = 1'b1;
        w_next = S_ID;
      end
      S_ID: begin
        w_next = S_EXE;
        if (w_cls.j) begin
          pc_wr  = 1'b1;
          npc_op = NPC_J;
          w_next = S_IF;
        end else if (w_cls.jal) begin
          pc_wr   = 1'b1;
          npc_op  = NPC_J;
          reg_wr  = 1'b1;
          reg_dst = DST_RA;
          wb_sel  = WB_PC4;
          w_next  = S_IF;
        end else if (w_cls.jr) begin
          pc_wr  = 1'b1;
          npc_op = NPC_RS;
          w_next = S_IF;
        end else if (w_cls.ill) begin
          illegal = 1'b1;
          w_next  = S_IF;
        end
      end
      S_EXE: begin
        w_next = S_WB;
        if (w_cls.subu) begin
          alu_op = ALU_SUB;
        end else if (w_cls.slt) begin
          alu_op = ALU_SLT;
        end else if (w_cls.ori) begin
          alu_src = 1'b1;
          alu_op  = ALU_OR;
        end else if (w_cls.addi) begin
          alu_src = 1'b1;
          alu_op  = ALU_ADDO;
          ext_op  = EXT_SIGN;
        end else if (w_cls.lui) begin
          alu_src = 1'b1;
          alu_op  = ALU_LUI;
          ext_op  = EXT_UPPER;
        end else if (w_cls.lw | w_cls.sw) begin
          alu_src = 1'b1;
          ext_op  = EXT_SIGN;
          w_next  = S_MEM;
        end else if (w_cls.beq) begin
          alu_op = ALU_SUB;
          ext_op = EXT_SIGN;
          pc_wr  = zero;
          npc_op = NPC_BR;
          w_next = S_IF;
        end else if (w_cls.bgtz) begin
          alu_op = ALU_GTZ;
          pc_wr  = condition;
          npc_op = NPC_BR;
          w_next = S_IF;
        end
      end
      S_MEM: begin
        if (w_cls.sw) begin
          mem_wr = 1'b1;
          w_next = S_IF;
        end else begin
          w_next = S_WB;
        end
      end
      S_WB: begin
        reg_wr  = 1'b1;
        reg_dst = w_rtype ? DST_RD : DST_RT;
        wb_sel  = w_cls.lw ? WB_MEM : WB_ALU;
        // a trapped addi must not commit its overflowed sum
        if (w_cls.addi && r_ov_q) begin
          reg_wr  = 1'b0;
          ov_trap = 1'b1;
        end
        w_next = S_IF;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - transaction-level randomized check of mc_ctrl
module tb_mc_ctrl;

  localparam int K_ADDU = 0, K_SUBU = 1, K_SLT = 2, K_JR = 3, K_ORI = 4, K_ADDI = 5,
                 K_LUI = 6, K_LW = 7, K_SW = 8, K_BEQ = 9, K_BGTZ = 10, K_J = 11,
                 K_JAL = 12, K_ILLOP = 13, K_ILLFN = 14, NK = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  op, funct;
  logic        zero, overflow, condition;
  logic        pc_wr, ir_wr, alu_src, reg_wr, mem_wr, illegal, ov_trap;
  logic [1:0]  npc_op, ext_op, reg_dst, wb_sel;
  logic [2:0]  alu_op, state;
  logic [31:0] instr_cnt;
  logic [20:0] outs;

  int n_vec = 0;
  int n_bad = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  assign outs = {pc_wr, ir_wr, npc_op, alu_src, alu_op, ext_op, reg_wr, reg_dst,
                 wb_sel, mem_wr, illegal, ov_trap, state};

  mc_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
    .overflow(overflow), .condition(condition), .pc_wr(pc_wr), .ir_wr(ir_wr),
    .npc_op(npc_op), .alu_src(alu_src), .alu_op(alu_op), .ext_op(ext_op),
    .reg_wr(reg_wr), .reg_dst(reg_dst), .wb_sel(wb_sel), .mem_wr(mem_wr),
    .illegal(illegal), .ov_trap(ov_trap), .state(state), .instr_cnt(instr_cnt)
  );

  typedef struct {
    int         cycles;
    int         pcw;
    logic [1:0] npc;
    int         regw;
    logic [1:0] rdst;
    logic [1:0] wbs;
    int         memw;
    int         ill;
    int         ovt;
    int         exe;
    logic       src;
    logic [2:0] aop;
    logic [1:0] ext;
  } exp_t;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void encode(input int k, output logic [5:0] o, output logic [5:0] f);
    f = 6'($urandom);
    case (k)
      K_ADDU:  begin o = 6'b000000; f = 6'b100001; end
      K_SUBU:  begin o = 6'b000000; f = 6'b100011; end
      K_SLT:   begin o = 6'b000000; f = 6'b101010; end
      K_JR:    begin o = 6'b000000; f = 6'b001000; end
      K_ORI:   o = 6'b001101;
      K_ADDI:  o = 6'b001000;
      K_LUI:   o = 6'b001111;
      K_LW:    o = 6'b100011;
      K_SW:    o = 6'b101011;
      K_BEQ:   o = 6'b000100;
      K_BGTZ:  o = 6'b000111;
      K_J:     o = 6'b000010;
      K_JAL:   o = 6'b000011;
      K_ILLOP: o = ($urandom_range(0, 1) != 0) ? 6'b111111 : 6'b000001;
      default: begin o = 6'b000000; f = 6'b000000; end
    endcase
  endfunction

  // What one instruction should do overall, from the instruction table.
  function automatic exp_t model(input int k, input logic z, input logic ov, input logic c);
    exp_t e;
    e.cycles = 4; e.pcw = 0; e.npc = 2'b00; e.regw = 1; e.rdst = 2'b00; e.wbs = 2'b00;
    e.memw = 0; e.ill = 0; e.ovt = 0; e.exe = 1; e.src = 1'b0; e.aop = 3'b000; e.ext = 2'b00;
    case (k)
      K_ADDU: e.rdst = 2'b01;
      K_SUBU: begin e.rdst = 2'b01; e.aop = 3'b001; end
      K_SLT:  begin e.rdst = 2'b01; e.aop = 3'b011; end
      K_ORI:  begin e.src = 1'b1; e.aop = 3'b010; end
      K_ADDI: begin
        e.src = 1'b1; e.aop = 3'b100; e.ext = 2'b01;
        e.regw = ov ? 0 : 1; e.ovt = ov ? 1 : 0;
      end
      K_LUI:  begin e.src = 1'b1; e.aop = 3'b101; e.ext = 2'b10; end
      K_LW:   begin e.cycles = 5; e.src = 1'b1; e.ext = 2'b01; e.wbs = 2'b01; end
      K_SW:   begin e.src = 1'b1; e.ext = 2'b01; e.regw = 0; e.memw = 1; end
      K_BEQ:  begin
        e.cycles = 3; e.regw = 0; e.aop = 3'b001; e.ext = 2'b01;
        e.pcw = z ? 1 : 0; e.npc = 2'b01;
      end
      K_BGTZ: begin
        e.cycles = 3; e.regw = 0; e.aop = 3'b110; e.pcw = c ? 1 : 0; e.npc = 2'b01;
      end
      K_J:    begin e.cycles = 2; e.exe = 0; e.regw = 0; e.pcw = 1; e.npc = 2'b10; end
      K_JAL:  begin
        e.cycles = 2; e.exe = 0; e.pcw = 1; e.npc = 2'b10; e.rdst = 2'b10; e.wbs = 2'b10;
      end
      K_JR:   begin e.cycles = 2; e.exe = 0; e.regw = 0; e.pcw = 1; e.npc = 2'b11; end
      default: begin e.cycles = 2; e.exe = 0; e.regw = 0; e.ill = 1; end
    endcase
    return e;
  endfunction

  // Entered at a falling edge while the DUT sits in IF; leaves at the next IF.
  task automatic run_instr(input int k, input bit force_f, input logic fz, input logic fov,
                           input logic fc);
    logic [5:0] o, f;
    logic z2 = 1'b0, ov2 = 1'b0, c2 = 1'b0;
    int cyc = 0, n_ir = 0, n_pc = 0, n_rw = 0, n_mw = 0, n_ill = 0, n_ovt = 0, n_exe = 0;
    logic [1:0] s_npc = 2'b00, s_rdst = 2'b00, s_wbs = 2'b00, s_ext = 2'b00;
    logic s_src = 1'b0;
    logic [2:0] s_aop = 3'b000;
    bit done = 0;
    exp_t e;
    string t;
    t = $sformatf("k%0d", k);
    encode(k, o, f);
    op = o; funct = f;
    zero = force_f ? fz : 1'($urandom_range(0, 1));
    overflow = force_f ? fov : 1'($urandom_range(0, 1));
    condition = force_f ? fc : 1'($urandom_range(0, 1));
    #1;
    check({t, " if_state"}, state, 3'd1);
    check({t, " if_enables"}, {ir_wr, pc_wr, npc_op}, 4'b1100);
    for (int i = 1; i < 8 && !done; i++) begin
      @(posedge clk);
      #1;
      zero = force_f ? fz : 1'($urandom_range(0, 1));
      overflow = force_f ? fov : 1'($urandom_range(0, 1));
      condition = force_f ? fc : 1'($urandom_range(0, 1));
      if (i == 2) begin z2 = zero; ov2 = overflow; c2 = condition; end
      @(negedge clk);
      if (state == 3'd1) begin
        done = 1;
        cyc = i;
      end else begin
        if (ir_wr) n_ir++;
        if (pc_wr) begin n_pc++; s_npc = npc_op; end
        if (reg_wr) begin n_rw++; s_rdst = reg_dst; s_wbs = wb_sel; end
        if (mem_wr) n_mw++;
        if (illegal) n_ill++;
        if (ov_trap) n_ovt++;
        if (state == 3'd3) begin n_exe++; s_src = alu_src; s_aop = alu_op; s_ext = ext_op; end
      end
    end
    check({t, " returned_to_if"}, done, 1'b1);
    e = model(k, z2, ov2, c2);
    exp_cnt++;
    check({t, " cycles"}, cyc, e.cycles);
    check({t, " extra_ir_wr"}, n_ir, 0);
    check({t, " pc_wr_count"}, n_pc, e.pcw);
    if (e.pcw > 0) check({t, " npc_op"}, s_npc, e.npc);
    check({t, " reg_wr_count"}, n_rw, e.regw);
    if (e.regw > 0) check({t, " reg_dst_wb_sel"}, {s_rdst, s_wbs}, {e.rdst, e.wbs});
    check({t, " mem_wr_count"}, n_mw, e.memw);
    check({t, " illegal_count"}, n_ill, e.ill);
    check({t, " ov_trap_count"}, n_ovt, e.ovt);
    check({t, " exe_cycles"}, n_exe, e.exe);
    if (e.exe > 0) check({t, " alu_ctrl"}, {s_src, s_aop, s_ext}, {e.src, e.aop, e.ext});
    check({t, " instr_cnt"}, instr_cnt, exp_cnt);
  endtask

  initial begin
    rst_n = 1'b0; op = '0; funct = '0; zero = 1'b0; overflow = 1'b0; condition = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", outs, '0);
    check("reset_cnt", instr_cnt, 0);
    rst_n = 1'b1;
    #1;
    check("idle_outputs", outs, '0);
    @(negedge clk);
    check("first_if", {state, ir_wr, pc_wr}, {3'd1, 2'b11});
    check("first_if_cnt", instr_cnt, 0);

    run_instr(K_ADDU, 1, 1'b0, 1'b0, 1'b0);
    run_instr(K_ADDI, 1, 1'b0, 1'b1, 1'b0);
    run_instr(K_ADDI, 1, 1'b0, 1'b0, 1'b0);
    run_instr(K_BEQ, 1, 1'b1, 1'b0, 1'b0);
    run_instr(K_BEQ, 1, 1'b0, 1'b0, 1'b1);
    run_instr(K_BGTZ, 1, 1'b0, 1'b0, 1'b1);
    run_instr(K_BGTZ, 1, 1'b1, 1'b1, 1'b0);
    run_instr(K_LW, 0, 1'b0, 1'b0, 1'b0);
    run_instr(K_SW, 0, 1'b0, 1'b0, 1'b0);
    run_instr(K_ILLOP, 0, 1'b0, 1'b0, 1'b0);
    run_instr(K_ILLFN, 0, 1'b0, 1'b0, 1'b0);
    run_instr(K_J, 0, 1'b0, 1'b0, 1'b0);
    run_instr(K_JAL, 0, 1'b0, 1'b0, 1'b0);
    run_instr(K_JR, 0, 1'b0, 1'b0, 1'b0);
    run_instr(K_ADDI, 1, 1'b0, 1'b1, 1'b0);

    // Abort an addu in EXE with an asynchronous reset.
    op = 6'b000000; funct = 6'b100001;
    @(negedge clk);
    @(negedge clk);
    check("abort_in_exe", state, 3'd3);
    #2 rst_n = 1'b0;
    #1;
    check("abort_outputs", outs, '0);
    check("abort_cnt", instr_cnt, 0);
    exp_cnt = 0;
    @(posedge clk);
    #1;
    check("abort_no_reg_wr", {state, reg_wr}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_restart_if", state, 3'd1);

    for (int n = 0; n < 80; n++)
      run_instr($urandom_range(0, NK - 1), 0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
